// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB-first, one bit
// per clock, for repeat_cnt+1 frames separated by gap idle cycles.
module seq_pattern_gen #(
    parameter int               WIDTH           = 8,
    parameter logic [WIDTH-1:0] PATTERN_DEFAULT = 8'b1001_0110
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic             use_default,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       repeat_cnt,
    input  logic [3:0]       gap,
    input  logic             idle_level,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int              CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0] patReg;
    logic [CW-1:0]    bitCnt;
    logic [3:0]       framesLeft;
    logic [3:0]       gapReg;
    logic [3:0]       gapCnt;
    logic [WIDTH-1:0] selPattern;

    assign selPattern = use_default ? PATTERN_DEFAULT : pattern;

    // shiftReg[WIDTH-1] always mirrors the bit currently on ser_out while in SHIFT,
    // so outputs are computed from next-state and the first bit appears at the accept edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            shiftReg    <= '0;
            patReg      <= '0;
            bitCnt      <= '0;
            framesLeft  <= '0;
            gapReg      <= '0;
            gapCnt      <= '0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            ser_out     <= 1'b0;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else if (abort && state != IDLE) begin
            state       <= IDLE;
            bitCnt      <= '0;
            gapCnt      <= '0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            ser_out     <= idle_level;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state       <= SHIFT;
                        shiftReg    <= selPattern;
                        patReg      <= selPattern;
                        framesLeft  <= repeat_cnt;
                        gapReg      <= gap;
                        bitCnt      <= '0;
                        ready       <= 1'b0;
                        busy        <= 1'b1;
                        ser_out     <= selPattern[WIDTH-1];
                        ser_valid   <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        ready       <= 1'b1;
                        busy        <= 1'b0;
                        ser_out     <= idle_level;
                        ser_valid   <= 1'b0;
                        frame_start <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bitCnt != LAST_BIT) begin
                        shiftReg    <= {shiftReg[WIDTH-2:0], 1'b0};
                        ser_out     <= shiftReg[WIDTH-2];
                        bitCnt      <= bitCnt + 1'b1;
                        frame_start <= 1'b0;
                    end else if (framesLeft == 4'd0) begin
                        state       <= DONE;
                        bitCnt      <= '0;
                        busy        <= 1'b0;
                        ser_out     <= idle_level;
                        ser_valid   <= 1'b0;
                        frame_start <= 1'b0;
                        done        <= 1'b1;
                    end else if (gapReg == 4'd0) begin
                        shiftReg    <= patReg;
                        ser_out     <= patReg[WIDTH-1];
                        bitCnt      <= '0;
                        framesLeft  <= framesLeft - 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        state       <= GAP;
                        bitCnt      <= '0;
                        gapCnt      <= 4'd1;
                        ser_out     <= idle_level;
                        ser_valid   <= 1'b0;
                        frame_start <= 1'b0;
                    end
                end
                GAP: begin
                    if (gapCnt == gapReg) begin
                        state       <= SHIFT;
                        shiftReg    <= patReg;
                        ser_out     <= patReg[WIDTH-1];
                        ser_valid   <= 1'b1;
                        frame_start <= 1'b1;
                        framesLeft  <= framesLeft - 1'b1;
                        gapCnt      <= '0;
                    end else begin
                        gapCnt  <= gapCnt + 1'b1;
                        ser_out <= idle_level;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    ser_out <= idle_level;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: per-scenario tasks with hand-computed
// expected serial streams, handshake timing, abort and reset behaviour.
module tb_seq_pattern_gen;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       start;
    logic       use_default;
    logic [7:0] pattern;
    logic [3:0] repeat_cnt;
    logic [3:0] gap;
    logic       idle_level;
    logic       abort;
    logic       ready, busy, ser_out, ser_valid, frame_start, done;

    int vectors = 0;
    int miscompares = 0;

    seq_pattern_gen dut (
        .Clock(Clock), .Reset(Reset), .start(start), .use_default(use_default),
        .pattern(pattern), .repeat_cnt(repeat_cnt), .gap(gap),
        .idle_level(idle_level), .abort(abort), .ready(ready), .busy(busy),
        .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
        .done(done)
    );

    always #5 Clock = ~Clock;

    // Advance one rising edge and settle; outputs read afterwards belong to that edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 0; use_default = 0; pattern = 8'h00;
        repeat_cnt = 0; gap = 0; idle_level = 0; abort = 0;
        tick(); tick();
        vectors++;
        if ({ready, busy, ser_out, ser_valid, frame_start, done} !== 6'b100000) begin
            $display("[TB] FAIL reset_outputs got=%b want=100000",
                     {ready, busy, ser_out, ser_valid, frame_start, done});
            miscompares++;
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_default_pattern();
        logic [7:0] exp = 8'b1001_0110;
        use_default = 1; repeat_cnt = 0; gap = 0; idle_level = 0; start = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start = 0;
            vectors++;
            if ({ser_out, ser_valid, frame_start} !== {exp[7-i], 1'b1, (i == 0)}) begin
                $display("[TB] FAIL default_bit%0d got=%b want=%b", i,
                         {ser_out, ser_valid, frame_start}, {exp[7-i], 1'b1, (i == 0)});
                miscompares++;
            end
        end
        tick();
        vectors++;
        if ({done, ready, ser_valid, busy} !== 4'b1000) begin
            $display("[TB] FAIL default_done got=%b want=1000", {done, ready, ser_valid, busy});
            miscompares++;
        end
        tick();
        vectors++;
        if ({done, ready} !== 2'b01) begin
            $display("[TB] FAIL default_ready got=%b want=01", {done, ready});
            miscompares++;
        end
        use_default = 0;
    endtask

    task automatic test_gap_repeat();
        logic [7:0] exp = 8'hA5;
        logic       eo, ev, ef, ed;
        pattern = 8'hA5; repeat_cnt = 2; gap = 3; idle_level = 1; start = 1;
        for (int c = 0; c < 32; c++) begin
            tick();
            start = 0;
            if (c == 0) begin pattern = 8'h00; gap = 0; repeat_cnt = 0; end
            if (c < 30) begin
                int pos = c % 11;
                ev = (pos < 8);
                eo = ev ? exp[7-pos] : 1'b1;
                ef = (pos == 0);
                ed = 1'b0;
            end else begin
                ev = 0; eo = 1'b1; ef = 0; ed = (c == 30);
            end
            vectors++;
            if ({ser_out, ser_valid, frame_start, done} !== {eo, ev, ef, ed}) begin
                $display("[TB] FAIL gap_cycle%0d got=%b want=%b", c,
                         {ser_out, ser_valid, frame_start, done}, {eo, ev, ef, ed});
                miscompares++;
            end
        end
        vectors++;
        if (ready !== 1'b1) begin
            $display("[TB] FAIL gap_ready got=%b want=1", ready);
            miscompares++;
        end
        idle_level = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp = 8'hF0;
        pattern = 8'hF0; repeat_cnt = 1; gap = 0; start = 1;
        for (int c = 0; c < 17; c++) begin
            tick();
            start = 0;
            pattern = 8'h0F;
            vectors++;
            if (c < 16) begin
                if ({ser_out, ser_valid, frame_start} !== {exp[7-(c%8)], 1'b1, (c % 8 == 0)}) begin
                    $display("[TB] FAIL b2b_bit%0d got=%b want=%b", c,
                             {ser_out, ser_valid, frame_start}, {exp[7-(c%8)], 1'b1, (c % 8 == 0)});
                    miscompares++;
                end
            end else if ({done, ser_valid} !== 2'b10) begin
                $display("[TB] FAIL b2b_done got=%b want=10", {done, ser_valid});
                miscompares++;
            end
        end
        tick();
    endtask

    task automatic test_start_held();
        int fsCount = 0;
        use_default = 1; repeat_cnt = 0; gap = 0; start = 1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (frame_start) fsCount++;
        end
        // edges k..k+9: one frame, done at k+8, ready at k+9 while start still high
        vectors++;
        if ({fsCount[3:0], ser_valid, ready} !== {4'd1, 1'b0, 1'b1}) begin
            $display("[TB] FAIL held_first got=%0d/%b/%b want=1/0/1", fsCount, ser_valid, ready);
            miscompares++;
        end
        tick();
        start = 0;
        vectors++;
        if ({ser_valid, frame_start, ser_out} !== 3'b111) begin
            $display("[TB] FAIL held_second_start got=%b want=111", {ser_valid, frame_start, ser_out});
            miscompares++;
        end
        fsCount = 0;
        for (int c = 1; c < 20; c++) begin
            start = (c == 2);
            tick();
            if (frame_start) fsCount++;
        end
        start = 0;
        vectors++;
        if ({fsCount, ser_valid, ready} !== {32'd0, 1'b0, 1'b1}) begin
            $display("[TB] FAIL busy_start_dropped frames=%0d valid=%b ready=%b want 0/0/1",
                     fsCount, ser_valid, ready);
            miscompares++;
        end
        use_default = 0;
    endtask

    task automatic test_abort();
        int doneSeen = 0;
        pattern = 8'h81; repeat_cnt = 3; gap = 0; start = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            start = 0;
        end
        abort = 1;
        tick();
        abort = 0;
        vectors++;
        if ({ready, ser_valid, busy} !== 3'b100) begin
            $display("[TB] FAIL abort_state got=%b want=100", {ready, ser_valid, busy});
            miscompares++;
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done || ser_valid) doneSeen++;
        end
        vectors++;
        if (doneSeen !== 0) begin
            $display("[TB] FAIL abort_quiet got=%0d want=0", doneSeen);
            miscompares++;
        end
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        vectors++;
        if ({ready, ser_valid, busy} !== 3'b100) begin
            $display("[TB] FAIL abort_idle_start got=%b want=100", {ready, ser_valid, busy});
            miscompares++;
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp = 8'hC3;
        int leak = 0;
        pattern = 8'h3C; repeat_cnt = 2; gap = 1; idle_level = 1; start = 1;
        for (int c = 0; c < 6; c++) begin
            tick();
            start = 0;
        end
        Reset = 1;
        tick();
        Reset = 0;
        vectors++;
        if ({ready, busy, ser_out, ser_valid, frame_start, done} !== 6'b100000) begin
            $display("[TB] FAIL midreset_outputs got=%b want=100000",
                     {ready, busy, ser_out, ser_valid, frame_start, done});
            miscompares++;
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ser_valid || done) leak++;
        end
        vectors++;
        if (leak !== 0) begin
            $display("[TB] FAIL midreset_quiet got=%0d want=0", leak);
            miscompares++;
        end
        pattern = 8'hC3; repeat_cnt = 0; gap = 0; start = 1;
        for (int c = 0; c < 8; c++) begin
            tick();
            start = 0;
            vectors++;
            if ({ser_out, ser_valid} !== {exp[7-c], 1'b1}) begin
                $display("[TB] FAIL fresh_bit%0d got=%b want=%b", c, {ser_out, ser_valid}, {exp[7-c], 1'b1});
                miscompares++;
            end
        end
        tick();
        vectors++;
        if ({done, ser_out} !== 2'b11) begin
            $display("[TB] FAIL fresh_done got=%b want=11", {done, ser_out});
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_default_pattern();
        test_gap_repeat();
        test_back_to_back();
        test_start_held();
        test_abort();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
